// File: rtl/npc_ras.sv
// Next-PC generator with a circular return-address stack that predicts jr targets
// and counts taken branches and return mispredictions.
module npc_ras #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          RAS_DEPTH = 4,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             D_valid,
    input  logic [2:0]       NPCOp,
    input  logic [31:0]      D_PC,
    input  logic [25:0]      D_Imm26,
    input  logic [15:0]      D_Imm16,
    input  logic [31:0]      D_RS,
    input  logic [31:0]      D_RT,
    output logic [31:0]      F_PC,
    output logic             redirect,
    output logic [31:0]      ras_top,
    output logic [4:0]       ras_cnt,
    output logic             ras_miss,
    output logic [CNT_W-1:0] br_taken_cnt,
    output logic [CNT_W-1:0] ras_miss_cnt
);
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_JR   = 3'b100;
    localparam logic [2:0] OP_JALR = 3'b101;
    localparam logic [2:0] OP_BGEZ = 3'b110;
    localparam logic [2:0] OP_BLTZ = 3'b111;

    logic [31:0]      f_pc_q, f_pc_d;
    logic [31:0]      mem_q [RAS_DEPTH];
    logic [31:0]      mem_d [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             miss_q, miss_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic        act;
    logic [2:0]  op;
    logic        taken;
    logic        is_branch;
    logic [31:0] target;
    logic [31:0] br_target;
    logic [31:0] top_val;
    logic        push;
    logic        pop;
    logic        mispredict;

    assign act = en & D_valid;
    // An inactive slot behaves as a plain sequential step, whatever NPCOp says.
    assign op  = act ? NPCOp : OP_SEQ;

    assign br_target = D_PC + 32'd4 + {{14{D_Imm16[15]}}, D_Imm16, 2'b00};

    always_comb begin
        taken     = 1'b0;
        is_branch = 1'b0;
        target    = br_target;
        unique case (op)
            OP_SEQ:  taken = 1'b0;
            OP_BEQ:  begin taken = (D_RS == D_RT); is_branch = 1'b1; end
            OP_BNE:  begin taken = (D_RS != D_RT); is_branch = 1'b1; end
            OP_BGEZ: begin taken = ~D_RS[31];      is_branch = 1'b1; end
            OP_BLTZ: begin taken = D_RS[31];       is_branch = 1'b1; end
            OP_JAL:  begin taken = 1'b1; target = {D_PC[31:28], D_Imm26, 2'b00}; end
            OP_JR,
            OP_JALR: begin taken = 1'b1; target = D_RS; end
            default: taken = 1'b0;
        endcase
    end

    assign redirect   = act & taken;
    assign top_val    = (cnt_q != 5'd0) ? mem_q[ptr_q - PW'(1)] : 32'd0;
    assign push       = (op == OP_JAL) || (op == OP_JALR);
    assign pop        = (op == OP_JR);
    // The prediction is only scored; the jr target always comes from D_RS.
    assign mispredict = pop && ((cnt_q == 5'd0) || (top_val != D_RS));

    always_comb begin
        f_pc_d     = f_pc_q;
        mem_d      = mem_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        miss_d     = 1'b0;
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (en) begin
            f_pc_d = redirect ? target : f_pc_q + 32'd4;
            miss_d = mispredict;
            if (push) begin
                mem_d[ptr_q] = D_PC + 32'd8;
                ptr_d        = ptr_q + PW'(1);
                if (cnt_q != 5'(RAS_DEPTH))
                    cnt_d = cnt_q + 5'd1;
            end else if (pop && cnt_q != 5'd0) begin
                ptr_d = ptr_q - PW'(1);
                cnt_d = cnt_q - 5'd1;
            end
            if (is_branch && taken && br_cnt_q != '1)
                br_cnt_d = br_cnt_q + CNT_W'(1);
            if (mispredict && miss_cnt_q != '1)
                miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_pc_q     <= RESET_PC;
            for (int i = 0; i < RAS_DEPTH; i++)
                mem_q[i] <= 32'd0;
            ptr_q      <= '0;
            cnt_q      <= 5'd0;
            miss_q     <= 1'b0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            f_pc_q     <= f_pc_d;
            mem_q      <= mem_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            miss_q     <= miss_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign F_PC         = f_pc_q;
    assign ras_top      = top_val;
    assign ras_cnt      = cnt_q;
    assign ras_miss     = miss_q;
    assign br_taken_cnt = br_cnt_q;
    assign ras_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_npc_ras.sv
// Directed bench for npc_ras: sequential fetch, branches, jal/jr return stack,
// overflow/underflow, stall behaviour and asynchronous reset.
module tb_npc_ras;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        D_valid = 1'b0;
    logic [2:0]  NPCOp = 3'b000;
    logic [31:0] D_PC = 32'd0;
    logic [25:0] D_Imm26 = 26'd0;
    logic [15:0] D_Imm16 = 16'd0;
    logic [31:0] D_RS = 32'd0;
    logic [31:0] D_RT = 32'd0;
    logic [31:0] F_PC;
    logic        redirect;
    logic [31:0] ras_top;
    logic [4:0]  ras_cnt;
    logic        ras_miss;
    logic [31:0] br_taken_cnt;
    logic [31:0] ras_miss_cnt;

    int vectors = 0;
    int errors  = 0;

    npc_ras dut (
        .clk(clk), .reset(reset), .en(en), .D_valid(D_valid), .NPCOp(NPCOp),
        .D_PC(D_PC), .D_Imm26(D_Imm26), .D_Imm16(D_Imm16), .D_RS(D_RS), .D_RT(D_RT),
        .F_PC(F_PC), .redirect(redirect), .ras_top(ras_top), .ras_cnt(ras_cnt),
        .ras_miss(ras_miss), .br_taken_cnt(br_taken_cnt), .ras_miss_cnt(ras_miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] pc,
                         input logic [25:0] i26, input logic [15:0] i16,
                         input logic [31:0] rs, input logic [31:0] rt);
        D_valid = v; NPCOp = op; D_PC = pc; D_Imm26 = i26; D_Imm16 = i16; D_RS = rs; D_RT = rt;
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #1;
        vectors++; if (F_PC !== 32'h3000) begin errors++; $display("FAIL reset_fpc got %h exp %h", F_PC, 32'h3000); end
        vectors++; if (ras_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", ras_cnt); end
        vectors++; if (ras_top !== 32'd0) begin errors++; $display("FAIL reset_top got %h exp 0", ras_top); end
        vectors++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL reset_miss got %b exp 0", ras_miss); end
        vectors++; if (br_taken_cnt !== 32'd0 || ras_miss_cnt !== 32'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", br_taken_cnt, ras_miss_cnt); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_seq();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h3004; exp_pc[1] = 32'h3008; exp_pc[2] = 32'h300C;
        drive(1'b0, 3'b011, 32'h0, 26'h0, 16'h0, 32'h0, 32'h0);
        vectors++; if (redirect !== 1'b0) begin errors++; $display("FAIL seq_redirect_invalid got %b exp 0", redirect); end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (F_PC !== exp_pc[i] || redirect !== 1'b0) begin errors++; $display("FAIL seq_fpc%0d got %h/%b exp %h/0", i, F_PC, redirect, exp_pc[i]); end
        end
    endtask

    task automatic test_branches();
        drive(1'b1, 3'b001, 32'h3004, 26'h0, 16'hFFFF, 32'd5, 32'd5);
        #1;
        vectors++; if (redirect !== 1'b1) begin errors++; $display("FAIL beq_redirect got %b exp 1", redirect); end
        step();
        vectors++; if (F_PC !== 32'h3004 || br_taken_cnt !== 32'd1) begin errors++; $display("FAIL beq_taken got %h cnt %0d exp 3004 cnt 1", F_PC, br_taken_cnt); end
        D_RT = 32'd6;
        #1;
        vectors++; if (redirect !== 1'b0) begin errors++; $display("FAIL beq_nt_redirect got %b exp 0", redirect); end
        step();
        vectors++; if (F_PC !== 32'h3008 || br_taken_cnt !== 32'd1) begin errors++; $display("FAIL beq_not_taken got %h cnt %0d exp 3008 cnt 1", F_PC, br_taken_cnt); end
        drive(1'b1, 3'b010, 32'h3100, 26'h0, 16'h0010, 32'd5, 32'd6);
        step();
        vectors++; if (F_PC !== 32'h3144 || br_taken_cnt !== 32'd2) begin errors++; $display("FAIL bne_taken got %h cnt %0d exp 3144 cnt 2", F_PC, br_taken_cnt); end
        drive(1'b1, 3'b110, 32'h0200, 26'h0, 16'h0000, 32'h8000_0000, 32'd0);
        step();
        vectors++; if (F_PC !== 32'h3148 || br_taken_cnt !== 32'd2) begin errors++; $display("FAIL bgez_neg got %h cnt %0d exp 3148 cnt 2", F_PC, br_taken_cnt); end
        drive(1'b1, 3'b111, 32'h0200, 26'h0, 16'h0000, 32'h8000_0000, 32'd0);
        step();
        vectors++; if (F_PC !== 32'h0204 || br_taken_cnt !== 32'd3) begin errors++; $display("FAIL bltz_neg got %h cnt %0d exp 204 cnt 3", F_PC, br_taken_cnt); end
    endtask

    task automatic test_jal_jr();
        drive(1'b1, 3'b011, 32'h3000, 26'h0000C10, 16'h0, 32'h0, 32'h0);
        step();
        vectors++; if (F_PC !== 32'h3040) begin errors++; $display("FAIL jal_fpc got %h exp 3040", F_PC); end
        vectors++; if (ras_top !== 32'h3008 || ras_cnt !== 5'd1) begin errors++; $display("FAIL jal_push got %h cnt %0d exp 3008 cnt 1", ras_top, ras_cnt); end
        drive(1'b1, 3'b100, 32'h3040, 26'h0, 16'h0, 32'h3008, 32'h0);
        step();
        vectors++; if (F_PC !== 32'h3008 || ras_cnt !== 5'd0 || ras_top !== 32'd0) begin errors++; $display("FAIL jr_pop got %h cnt %0d top %h exp 3008 cnt 0 top 0", F_PC, ras_cnt, ras_top); end
        vectors++; if (ras_miss !== 1'b0 || ras_miss_cnt !== 32'd0 || br_taken_cnt !== 32'd3) begin errors++; $display("FAIL jr_hit got miss %b cnt %0d br %0d exp 0 0 3", ras_miss, ras_miss_cnt, br_taken_cnt); end
    endtask

    task automatic test_overflow();
        logic [31:0] rets [4];
        rets[0] = 32'h18; rets[1] = 32'h14; rets[2] = 32'h10; rets[3] = 32'h0C;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'b011, 32'(i * 4), 26'h40, 16'h0, 32'h0, 32'h0);
            step();
        end
        vectors++; if (ras_cnt !== 5'd4 || ras_top !== 32'h18) begin errors++; $display("FAIL ovf_push got cnt %0d top %h exp 4 18", ras_cnt, ras_top); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b100, 32'h100, 26'h0, 16'h0, rets[i], 32'h0);
            step();
            vectors++; if (ras_miss !== 1'b0 || F_PC !== rets[i] || ras_cnt !== 5'(3 - i)) begin errors++; $display("FAIL ovf_pop%0d got miss %b pc %h cnt %0d exp 0 %h %0d", i, ras_miss, F_PC, ras_cnt, rets[i], 3 - i); end
        end
        drive(1'b1, 3'b100, 32'h100, 26'h0, 16'h0, 32'h40, 32'h0);
        step();
        vectors++; if (ras_miss !== 1'b1 || ras_miss_cnt !== 32'd1 || ras_cnt !== 5'd0 || F_PC !== 32'h40) begin errors++; $display("FAIL underflow got miss %b mcnt %0d cnt %0d pc %h exp 1 1 0 40", ras_miss, ras_miss_cnt, ras_cnt, F_PC); end
        drive(1'b0, 3'b000, 32'h0, 26'h0, 16'h0, 32'h0, 32'h0);
        step();
        vectors++; if (ras_miss !== 1'b0 || F_PC !== 32'h44) begin errors++; $display("FAIL miss_pulse got miss %b pc %h exp 0 44", ras_miss, F_PC); end
        drive(1'b1, 3'b101, 32'h100, 26'h0, 16'h0, 32'h500, 32'h0);
        step();
        vectors++; if (F_PC !== 32'h500 || ras_top !== 32'h108 || ras_cnt !== 5'd1 || ras_miss !== 1'b0) begin errors++; $display("FAIL jalr_push got pc %h top %h cnt %0d miss %b exp 500 108 1 0", F_PC, ras_top, ras_cnt, ras_miss); end
        drive(1'b1, 3'b100, 32'h500, 26'h0, 16'h0, 32'h200, 32'h0);
        step();
        vectors++; if (F_PC !== 32'h200 || ras_miss !== 1'b1 || ras_miss_cnt !== 32'd2 || ras_cnt !== 5'd0) begin errors++; $display("FAIL jr_mismatch got pc %h miss %b mcnt %0d cnt %0d exp 200 1 2 0", F_PC, ras_miss, ras_miss_cnt, ras_cnt); end
    endtask

    task automatic test_stall();
        drive(1'b1, 3'b011, 32'h50, 26'h100, 16'h0, 32'h0, 32'h0);
        step();
        vectors++; if (F_PC !== 32'h400 || ras_top !== 32'h58 || ras_miss !== 1'b0) begin errors++; $display("FAIL stall_setup got pc %h top %h miss %b exp 400 58 0", F_PC, ras_top, ras_miss); end
        en = 1'b0;
        drive(1'b1, 3'b100, 32'h400, 26'h0, 16'h0, 32'h1234, 32'h0);
        #1;
        vectors++; if (redirect !== 1'b0) begin errors++; $display("FAIL stall_redirect got %b exp 0", redirect); end
        step();
        vectors++; if (F_PC !== 32'h400 || ras_cnt !== 5'd1 || ras_top !== 32'h58 || ras_miss_cnt !== 32'd2 || br_taken_cnt !== 32'd3) begin errors++; $display("FAIL stall_hold got pc %h cnt %0d top %h m %0d b %0d exp 400 1 58 2 3", F_PC, ras_cnt, ras_top, ras_miss_cnt, br_taken_cnt); end
        en = 1'b1;
        step();
        vectors++; if (F_PC !== 32'h1234 || ras_cnt !== 5'd0 || ras_miss !== 1'b1 || ras_miss_cnt !== 32'd3) begin errors++; $display("FAIL stall_release got pc %h cnt %0d miss %b m %0d exp 1234 0 1 3", F_PC, ras_cnt, ras_miss, ras_miss_cnt); end
        en = 1'b0;
        step();
        vectors++; if (ras_miss !== 1'b0 || F_PC !== 32'h1234 || ras_miss_cnt !== 32'd3) begin errors++; $display("FAIL stall_miss_clear got miss %b pc %h m %0d exp 0 1234 3", ras_miss, F_PC, ras_miss_cnt); end
        en = 1'b1;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 3'b011, 32'h0, 26'h10, 16'h0, 32'h0, 32'h0);
        step();
        vectors++; if (ras_cnt !== 5'd1 || F_PC !== 32'h40) begin errors++; $display("FAIL areset_setup got cnt %0d pc %h exp 1 40", ras_cnt, F_PC); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (F_PC !== 32'h3000 || ras_cnt !== 5'd0 || ras_top !== 32'd0 || br_taken_cnt !== 32'd0 || ras_miss_cnt !== 32'd0) begin errors++; $display("FAIL areset got pc %h cnt %0d top %h b %0d m %0d exp 3000 0 0 0 0", F_PC, ras_cnt, ras_top, br_taken_cnt, ras_miss_cnt); end
        drive(1'b0, 3'b000, 32'h0, 26'h0, 16'h0, 32'h0, 32'h0);
        step();
        vectors++; if (F_PC !== 32'h3000) begin errors++; $display("FAIL areset_hold got pc %h exp 3000", F_PC); end
        @(negedge clk);
        reset = 1'b1;
        step();
        vectors++; if (F_PC !== 32'h3004) begin errors++; $display("FAIL areset_release got pc %h exp 3004", F_PC); end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branches();
        test_jal_jr();
        test_overflow();
        test_stall();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
